axis_2_fifo_adapter: RTL

AXIS_2_FIFO_ADAPTER -- requirements
Module: axis_2_fifo_adapter

---
 rtl/axis_2_fifo_adapter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/axis_2_fifo_adapter.sv
// AXI-Stream slave to FIFO write-port adapter.
// A two-entry skid buffer (output register + skid register) keeps a registered
// tready while sustaining one beat per cycle. A small packet tracker reports
// busy, per-packet length and the completed-packet count.
module axis_2_fifo_adapter #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int PKT_LEN_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_axis_tuser,
    input  logic [AXIS_DATA_WIDTH-1:0] i_axis_tdata,
    input  logic                       i_axis_tvalid,
    output logic                       o_axis_tready,
    input  logic                       i_axis_tlast,
    output logic [FIFO_DATA_WIDTH-1:0] o_fifo_data,
    output logic                       o_fifo_last,
    output logic                       o_fifo_w_stb,
    input  logic                       i_fifo_not_full,
    output logic                       o_busy,
    output logic                       o_pkt_done,
    output logic [PKT_LEN_WIDTH-1:0]   o_pkt_len,
    output logic [PKT_LEN_WIDTH-1:0]   o_pkt_count
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    localparam logic [PKT_LEN_WIDTH-1:0] CNT_MAX = {PKT_LEN_WIDTH{1'b1}};

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [PKT_LEN_WIDTH-1:0] sat_inc(input logic [PKT_LEN_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = CNT_MAX;
        end else begin
            sat_inc = v + PKT_LEN_WIDTH'(1);
        end
    endfunction

    // Skid buffer storage
    logic                       out_valid_r, out_valid_s;
    logic [AXIS_DATA_WIDTH-1:0] out_data_r, out_data_s;
    logic                       out_last_r, out_last_s;
    logic                       skid_valid_r, skid_valid_s;
    logic [AXIS_DATA_WIDTH-1:0] skid_data_r, skid_data_s;
    logic                       skid_last_r, skid_last_s;
    logic                       tready_r;

    // Packet tracking
    state_t                     state_r;
    logic                       busy_r;
    logic                       pkt_done_r;
    logic [PKT_LEN_WIDTH-1:0]   beat_cnt_r;
    logic [PKT_LEN_WIDTH-1:0]   pkt_len_r;
    logic [PKT_LEN_WIDTH-1:0]   pkt_count_r;

    logic accept_s;
    logic write_s;
    logic unused_tuser_s;

    assign unused_tuser_s = i_axis_tuser;
    assign accept_s       = i_axis_tvalid & tready_r;
    assign write_s        = out_valid_r & i_fifo_not_full;

    assign o_axis_tready  = tready_r;
    assign o_fifo_w_stb   = write_s;
    assign o_fifo_data    = FIFO_DATA_WIDTH'(out_data_r);
    assign o_fifo_last    = out_last_r;
    assign o_busy         = busy_r;
    assign o_pkt_done     = pkt_done_r;
    assign o_pkt_len      = pkt_len_r;
    assign o_pkt_count    = pkt_count_r;

    // Next state of the two buffer entries: refill the output register first
    // from the skid entry, then from the input; park extra beats in the skid.
    always_comb begin
        out_valid_s  = out_valid_r;
        out_data_s   = out_data_r;
        out_last_s   = out_last_r;
        skid_valid_s = skid_valid_r;
        skid_data_s  = skid_data_r;
        skid_last_s  = skid_last_r;
        if (!out_valid_r || write_s) begin
            if (skid_valid_r) begin
                out_valid_s  = 1'b1;
                out_data_s   = skid_data_r;
                out_last_s   = skid_last_r;
                skid_valid_s = 1'b0;
            end else if (accept_s) begin
                out_valid_s  = 1'b1;
                out_data_s   = i_axis_tdata;
                out_last_s   = i_axis_tlast;
            end else begin
                out_valid_s  = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_valid_s = 1'b1;
                skid_data_s  = i_axis_tdata;
                skid_last_s  = i_axis_tlast;
            end else begin
                skid_valid_s = skid_valid_r;
            end
        end
    end

    // Buffer registers; tready is registered as the inverse of next skid occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_last_r   <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
            skid_last_r  <= 1'b0;
            tready_r     <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_s;
            out_data_r   <= out_data_s;
            out_last_r   <= out_last_s;
            skid_valid_r <= skid_valid_s;
            skid_data_r  <= skid_data_s;
            skid_last_r  <= skid_last_s;
            tready_r     <= ~skid_valid_s;
        end
    end

    // Packet FSM and statistics; everything advances only on an actual FIFO write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            pkt_done_r  <= 1'b0;
            beat_cnt_r  <= '0;
            pkt_len_r   <= '0;
            pkt_count_r <= '0;
        end else begin
            pkt_done_r <= 1'b0;
            if (write_s) begin
                case (state_r)
                    IDLE: begin
                        if (!out_last_r) begin
                            state_r <= IN_PKT;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                    IN_PKT: begin
                        if (out_last_r) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= IN_PKT;
                            busy_r  <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
                if (out_last_r) begin
                    beat_cnt_r  <= '0;
                    pkt_len_r   <= sat_inc(beat_cnt_r);
                    pkt_count_r <= pkt_count_r + PKT_LEN_WIDTH'(1);
                    pkt_done_r  <= 1'b1;
                end else begin
                    beat_cnt_r  <= sat_inc(beat_cnt_r);
                end
            end
        end
    end

endmodule
